led_pwm_driver: RTL and testbench
=================================

# led_pwm_driver

LED output stage fed by the 8-bit Avalon PIO output register. Takes the PIO's pattern word and applies a software-selected display mode (static, blink, chase, off) plus global PWM brightness before driving the board LEDs. All control inputs are shadowed and applied only on PWM-period boundaries, so writes from the CPU side never produce partial-period glitches on the LEDs.

## Interface
- WIDTH, 8, number of LEDs / pattern bits
- PWM_BITS, 8, PWM counter and duty width
- PRESCALE, 50, clk cycles per PWM tick (≥1)
- STEP_PERIODS, 64, PWM periods per blink/chase step (≥1)
- clk  in  1  system clock
- reset_n  in  1  reset; asynchronous, active-low
- pattern_in  in  WIDTH  LED pattern, driven by the PIO output port
- duty  in  PWM_BITS  brightness; 0 = dark, all-ones = fully on
- mode  in  2  0 static, 1 blink, 2 chase, 3 off
- leds_out  out  WIDTH  registered LED drive, active-high
- period_strobe  out  1  one-cycle pulse at each PWM period end

## Operation
- Tick generator: prescale counter 0..PRESCALE-1; tick = 1 in the cycle where count == PRESCALE-1; count then wraps to 0.
- PWM counter pwm_cnt: increments on tick, wraps from 2^PWM_BITS-1 to 0. period_end = tick && pwm_cnt == all-ones.
- At period_end: pattern_sh <= pattern_in, duty_sh <= duty_eff, mode_sh <= mode. No other path updates shadows.
- State machine on mode_sh, states S_STATIC, S_BLINK, S_CHASE, S_OFF. Transitions occur only at period_end, to the state encoded by the incoming mode.
- Step counter: counts period_end events 0..STEP_PERIODS-1; step = period_end && count == STEP_PERIODS-1. Cleared to 0 on any state change.
- Frame per state:
  - S_STATIC: frame = pattern_sh.
  - S_BLINK: phase register; set to 1 on entering the state, toggles on each step; frame = phase ? pattern_sh : 0.
  - S_CHASE: rotate register; loaded from the new pattern on entry and whenever the latched pattern differs from the previous one; otherwise rotates left by 1 on step (MSB → bit 0). Pattern 0 stays 0.
  - S_OFF: frame = 0.
- PWM gate on = (duty_sh == all-ones) || (pwm_cnt < duty_sh). leds_out <= frame & {WIDTH{on}}.
- period_strobe <= period_end.

## Timing
- Reset: leds_out = 0, period_strobe = 0, all counters 0, pattern_sh = 0, duty_sh = 0, state S_STATIC, phase 1, rotate register 0.
- Input → LED latency: input change takes effect at the next period_end; leds_out reflects the new shadow one cycle later.
- period_strobe asserts in the cycle after period_end; period length = PRESCALE·2^PWM_BITS clk cycles.
- Duty d, 0 < d < max: LED on for d of 2^PWM_BITS ticks, starting at pwm_cnt = 0.
- Simultaneous mode change and step at the same period_end: the mode change wins; the step is discarded and the new state starts with count 0.
- Inputs are synchronous to clk; there is no CDC inside the block.
- Asynchronous reset mid-period: all state returns to reset values immediately; leds_out is 0 until the first period_end after release.

## Configuration
- LED_PWM_GAMMA_EN defined: duty_eff = (duty·duty) >> PWM_BITS, except all-ones maps to all-ones (perceptual brightness). The product is 2·PWM_BITS wide.
- Not defined: duty_eff = duty (linear).

## Structure
- Package led_drv_pkg: mode enum (MODE_STATIC=0, MODE_BLINK=1, MODE_CHASE=2, MODE_OFF=3) and the state typedef.
- Sub-module led_tick_gen: prescaler, PWM counter, and step counter. Outputs tick, pwm_cnt, period_end, and step, with a step-clear input.
- Top level contains the shadows, the FSM, the frame logic, and the output register.

## Test plan
Sim parameters: WIDTH=8, PWM_BITS=4, PRESCALE=2, STEP_PERIODS=2; period length 32 clk cycles.
- Reset release with pattern_in=0xA5, duty=0xF, mode=0 -> leds_out=0x00 until the first period_end, then 0xA5 constantly; period_strobe every 32 cycles.
- Static mode, duty=4 -> leds_out=0xA5 for 8 cycles (pwm_cnt 0..3), 0x00 for 24 cycles, repeating; duty=0 -> always 0x00.
- Blink mode, pattern 0x0F, duty=0xF -> 0x0F for 2 periods (64 cycles), then 0x00 for 64 cycles, repeating.
- Chase mode, pattern 0x81, duty=0xF -> 0x81, 0x03, 0x06 … changing every 64 cycles; pattern_in changed to 0x10 mid-step -> 0x10 at the next period_end.
- pattern_in change mid-period -> no leds_out change before period_end; mode=3 -> 0x00 from the next boundary.
- With LED_PWM_GAMMA_EN, duty=8 -> duty_eff=4 (8 of 32 cycles on); duty=0xF -> fully on. Without the macro, duty=8 -> 16 of 32 cycles on.

Source files
------------

// File: rtl/led_drv_pkg.sv
// rtl/led_drv_pkg.sv - shared mode/state types for the LED PWM driver
package led_drv_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_CHASE  = 2'd2,
    MODE_OFF    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_STATIC = 2'd0,
    S_BLINK  = 2'd1,
    S_CHASE  = 2'd2,
    S_OFF    = 2'd3
  } state_e;

  // Map the raw software mode field onto the display state it selects.
  function automatic state_e mode_to_state(input logic [1:0] m);
    state_e s;
    case (mode_e'(m))
      MODE_STATIC: s = S_STATIC;
      MODE_BLINK:  s = S_BLINK;
      MODE_CHASE:  s = S_CHASE;
      default:     s = S_OFF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// rtl/led_tick_gen.sv - prescaler, PWM period counter and blink/chase step counter
module led_tick_gen #(
  parameter int PWM_BITS     = 8,
  parameter int PRESCALE     = 50,
  parameter int STEP_PERIODS = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                step_clear,
  output logic                tick,
  output logic [PWM_BITS-1:0] pwm_cnt,
  output logic                period_end,
  output logic                step
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int ST_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(STEP_PERIODS - 1);

  logic [PS_W-1:0] presc_cnt;
  logic [ST_W-1:0] step_cnt;

  assign tick       = (presc_cnt == PS_LAST);
  assign period_end = tick && (pwm_cnt == '1);
  assign step       = period_end && (step_cnt == ST_LAST);

  // Prescaler: one PWM tick every PRESCALE clocks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_cnt <= '0;
    end else if (tick) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + 1'b1;
    end
  end

  // PWM counter advances on each tick and wraps naturally at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt <= '0;
    end else if (tick) begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // Step counter counts whole PWM periods; a state change restarts it so the
  // new state always gets a full first step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step_cnt <= '0;
    end else if (step_clear) begin
      step_cnt <= '0;
    end else if (period_end) begin
      if (step) begin
        step_cnt <= '0;
      end else begin
        step_cnt <= step_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_pwm_driver.sv
// rtl/led_pwm_driver.sv - LED display modes plus PWM brightness; LED_PWM_GAMMA_EN selects squared duty
module led_pwm_driver #(
  parameter int WIDTH        = 8,
  parameter int PWM_BITS     = 8,
  parameter int PRESCALE     = 50,
  parameter int STEP_PERIODS = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [WIDTH-1:0]    pattern_in,
  input  logic [PWM_BITS-1:0] duty,
  input  logic [1:0]          mode,
  output logic [WIDTH-1:0]    leds_out,
  output logic                period_strobe
);

  import led_drv_pkg::*;

  logic                tick_unused;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                period_end;
  logic                step;
  logic                state_change;

  logic [WIDTH-1:0]    pattern_sh;
  logic [PWM_BITS-1:0] duty_sh;
  logic [PWM_BITS-1:0] duty_eff;
  logic                phase;
  logic [WIDTH-1:0]    rot_q;
  logic [WIDTH-1:0]    frame;
  logic                pwm_on;

  state_e state_q;
  state_e state_d;

  led_tick_gen #(
    .PWM_BITS     (PWM_BITS),
    .PRESCALE     (PRESCALE),
    .STEP_PERIODS (STEP_PERIODS)
  ) u_tick_gen (
    .clk        (clk),
    .reset_n    (reset_n),
    .step_clear (state_change),
    .tick       (tick_unused),
    .pwm_cnt    (pwm_cnt),
    .period_end (period_end),
    .step       (step)
  );

`ifdef LED_PWM_GAMMA_EN
  logic [2*PWM_BITS-1:0] duty_ext;
  logic [2*PWM_BITS-1:0] duty_sq;
  assign duty_ext = {{PWM_BITS{1'b0}}, duty};
  assign duty_sq  = duty_ext * duty_ext;
  // Full scale is kept at full scale so "fully on" stays truly on.
  assign duty_eff = (duty == '1) ? duty : duty_sq[2*PWM_BITS-1:PWM_BITS];
`else
  assign duty_eff = duty;
`endif

  assign state_change = period_end && (state_d != state_q);

  // Shadow registers: CPU-side writes only become visible on a period boundary.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pattern_sh <= '0;
      duty_sh    <= '0;
    end else if (period_end) begin
      pattern_sh <= pattern_in;
      duty_sh    <= duty_eff;
    end
  end

  // FSM state register; the state doubles as the shadowed mode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_STATIC;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state follows the incoming mode at period_end; frame is chosen per state.
  always_comb begin
    state_d = state_q;
    frame   = '0;
    if (period_end) begin
      state_d = mode_to_state(mode);
    end
    case (state_q)
      S_STATIC: frame = pattern_sh;
      S_BLINK:  frame = phase ? pattern_sh : '0;
      S_CHASE:  frame = rot_q;
      default:  frame = '0;
    endcase
  end

  // Blink phase: visible on entry, flips every step; a step that coincides
  // with entry is ignored because entry takes priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase <= 1'b1;
    end else if (state_change && (state_d == S_BLINK)) begin
      phase <= 1'b1;
    end else if (step && (state_q == S_BLINK) && (state_d == S_BLINK)) begin
      phase <= ~phase;
    end
  end

  // Chase rotator: reload on entry or on a new pattern, else rotate left on step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rot_q <= '0;
    end else if (state_change && (state_d == S_CHASE)) begin
      rot_q <= pattern_in;
    end else if (period_end && (state_q == S_CHASE) && (state_d == S_CHASE)) begin
      if (pattern_in != pattern_sh) begin
        rot_q <= pattern_in;
      end else if (step) begin
        rot_q <= {rot_q[WIDTH-2:0], rot_q[WIDTH-1]};
      end
    end
  end

  // Each period opens with the LEDs on (pwm_cnt = 0) for duty_sh ticks.
  assign pwm_on = (duty_sh == '1) || (pwm_cnt < duty_sh);

  // Registered LED drive and period boundary strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      leds_out      <= '0;
      period_strobe <= 1'b0;
    end else begin
      leds_out      <= frame & {WIDTH{pwm_on}};
      period_strobe <= period_end;
    end
  end

endmodule

// File: tb/tb_led_pwm_driver.sv
// tb/tb_led_pwm_driver.sv - scoreboard bench for led_pwm_driver, one expected record per PWM period
module tb_led_pwm_driver;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] pattern_in = 8'hA5;
  logic [3:0] duty = 4'hF;
  logic [1:0] mode = 2'd0;
  logic [7:0] leds_out;
  logic       period_strobe;

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [7:0] val;
    int         on;
  } exp_t;

  typedef struct {
    logic [7:0] pat;
    logic [3:0] duty;
    logic [1:0] mode;
    int         dly;
    logic [7:0] exp_val;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[$];

  led_pwm_driver #(
    .WIDTH        (8),
    .PWM_BITS     (4),
    .PRESCALE     (2),
    .STEP_PERIODS (2)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pattern_in    (pattern_in),
    .duty          (duty),
    .mode          (mode),
    .leds_out      (leds_out),
    .period_strobe (period_strobe)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
    end
  endtask

  // Cycles per 32-cycle period that the LEDs should be lit for a given duty.
  function automatic int on_cycles(input logic [3:0] d);
    logic [3:0] de;
`ifdef LED_PWM_GAMMA_EN
    logic [7:0] sq;
    sq = {4'b0, d} * {4'b0, d};
    de = (d == 4'hF) ? 4'hF : sq[7:4];
`else
    de = d;
`endif
    return (de == 4'hF) ? 32 : 2 * int'(de);
  endfunction

  function automatic vec_t mk(input logic [7:0] p, input logic [3:0] d,
                              input logic [1:0] m, input int dl, input logic [7:0] e);
    vec_t v;
    v.pat = p; v.duty = d; v.mode = m; v.dly = dl; v.exp_val = e;
    return v;
  endfunction

  task automatic push_exp(input logic [7:0] val, input logic [3:0] d);
    exp_t e;
    e.val = val;
    e.on  = (val == 8'h00) ? 0 : on_cycles(d);
    if (e.on == 0) e.val = 8'h00;
    exp_q.push_back(e);
  endtask

  task automatic wait_strobe(input int idx);
    int n = 0;
    @(negedge clk);
    while (!period_strobe && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!period_strobe) check($sformatf("strobe_timeout_%0d", idx), 0, 1);
  endtask

  // Monitor: accumulate one PWM period of leds_out, compare at each strobe.
  initial begin
    logic [7:0] win_val;
    int win_on, win_len, win_idx;
    bit win_mixed;
    exp_t e;
    win_val = 8'h00; win_on = 0; win_len = 0; win_idx = 0; win_mixed = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (leds_out != 8'h00) begin
          if (win_on == 0) win_val = leds_out;
          else if (leds_out != win_val) win_mixed = 1'b1;
          win_on++;
        end
        win_len++;
        if (period_strobe) begin
          if (exp_q.size() == 0) begin
            check($sformatf("win%0d_unexpected", win_idx), 1, 0);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("win%0d_value", win_idx), int'(win_val), int'(e.val));
            check($sformatf("win%0d_on_cycles", win_idx), win_on, e.on);
            check($sformatf("win%0d_glitch", win_idx), int'(win_mixed), 0);
            if (win_idx > 0) check($sformatf("win%0d_period_len", win_idx), win_len, 32);
          end
          win_idx++;
          win_val = 8'h00; win_on = 0; win_len = 0; win_mixed = 1'b0;
        end
      end
    end
  end

  // Stimulus: entry j is applied in window j and appears in window j+2.
  initial begin
    int n;
    vecs.push_back(mk(8'hA5, 4'h4, 2'd0, 0, 8'hA5));
    vecs.push_back(mk(8'hA5, 4'h0, 2'd0, 0, 8'h00));
    vecs.push_back(mk(8'hA5, 4'h8, 2'd0, 3, 8'hA5));
    vecs.push_back(mk(8'h0F, 4'hF, 2'd1, 0, 8'h0F));
    vecs.push_back(mk(8'h0F, 4'hF, 2'd1, 0, 8'h0F));
    vecs.push_back(mk(8'h0F, 4'hF, 2'd1, 0, 8'h00));
    vecs.push_back(mk(8'h0F, 4'hF, 2'd1, 0, 8'h00));
    vecs.push_back(mk(8'h0F, 4'hF, 2'd1, 0, 8'h0F));
    vecs.push_back(mk(8'h81, 4'hF, 2'd2, 0, 8'h81));
    vecs.push_back(mk(8'h81, 4'hF, 2'd2, 0, 8'h81));
    vecs.push_back(mk(8'h81, 4'hF, 2'd2, 0, 8'h03));
    vecs.push_back(mk(8'h81, 4'hF, 2'd2, 0, 8'h03));
    vecs.push_back(mk(8'h81, 4'hF, 2'd2, 0, 8'h06));
    vecs.push_back(mk(8'h10, 4'hF, 2'd2, 10, 8'h10));
    vecs.push_back(mk(8'h10, 4'hF, 2'd2, 0, 8'h20));
    vecs.push_back(mk(8'hA5, 4'hF, 2'd0, 5, 8'hA5));
    vecs.push_back(mk(8'hA5, 4'hF, 2'd3, 0, 8'h00));
    vecs.push_back(mk(8'h3C, 4'hF, 2'd3, 20, 8'h00));
    vecs.push_back(mk(8'h3C, 4'hF, 2'd0, 0, 8'h3C));
    vecs.push_back(mk(8'h3C, 4'hF, 2'd0, 0, 8'h3C));
    vecs.push_back(mk(8'h81, 4'hF, 2'd2, 0, 8'h81));
    vecs.push_back(mk(8'h81, 4'hF, 2'd2, 0, 8'h81));
    vecs.push_back(mk(8'h81, 4'hF, 2'd2, 0, 8'h03));

    repeat (3) @(negedge clk);
    check("reset_leds_out", int'(leds_out), 0);
    check("reset_period_strobe", int'(period_strobe), 0);

    push_exp(8'h00, 4'h0);
    push_exp(8'hA5, 4'hF);
    mon_en  = 1'b1;
    reset_n = 1'b1;

    foreach (vecs[j]) begin
      wait_strobe(j);
      repeat (vecs[j].dly) @(negedge clk);
      pattern_in = vecs[j].pat;
      duty       = vecs[j].duty;
      mode       = vecs[j].mode;
      push_exp(vecs[j].exp_val, vecs[j].duty);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
